// File: rtl/cc_pos_pkg.sv
// Shared definitions for the position tracker: FSM encoding, defaults and
// the end-stop helper used to size the position range.
package cc_pos_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      HOLD = 2'b01,
      LOCK = 2'b10
   } state_e;

   localparam int DEF_DATAWIDTH   = 3;
   localparam int DEF_HOLD_CYCLES = 12500000;
   localparam int DEF_HOLD_WIDTH  = 24;

   // Upper end stop for a position bus of the given width.
   function automatic int unsigned pos_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/cc_hold_timer.sv
// Loadable down-counter that times the hold-off after each step.
// Load has priority; counting stops at zero.
module cc_hold_timer
   import cc_pos_pkg::*;
#(
   parameter int WIDTH = DEF_HOLD_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   input  logic             en_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i)
         cnt_d = load_val_i;
      else if (en_i && (cnt_q != '0))
         cnt_d = cnt_q - WIDTH'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cc_pos_tracker.sv
// Saturating up/down position register with hold-off auto-repeat and an
// end-stop lock; its registered position feeds the zero comparator.
module cc_pos_tracker
   import cc_pos_pkg::*;
#(
   parameter int                  DATAWIDTH   = DEF_DATAWIDTH,
   parameter logic [DATAWIDTH-1:0] INIT_POS   = 3'd4,
   parameter int                  HOLD_CYCLES = DEF_HOLD_CYCLES,
   parameter int                  HOLD_WIDTH  = DEF_HOLD_WIDTH
) (
   input  logic                 CC_POSTRACKER_CLOCK_50,
   input  logic                 CC_POSTRACKER_RESET_InHigh,
   input  logic                 CC_POSTRACKER_load_InLow,
   input  logic [DATAWIDTH-1:0] CC_POSTRACKER_loadData_InBUS,
   input  logic                 CC_POSTRACKER_up_InLow,
   input  logic                 CC_POSTRACKER_down_InLow,
   output logic [DATAWIDTH-1:0] CC_POSTRACKER_data_OutBUS,
   output logic                 CC_POSTRACKER_moved_OutHigh,
   output logic                 CC_POSTRACKER_limit_OutHigh
);

   localparam logic [DATAWIDTH-1:0]  POS_MAX     = DATAWIDTH'(pos_max(DATAWIDTH));
   localparam logic [HOLD_WIDTH-1:0] HOLD_RELOAD = HOLD_WIDTH'(HOLD_CYCLES - 1);

   state_e                state_q, state_d;
   logic [DATAWIDTH-1:0]  pos_q, pos_d;
   logic                  moved_q, moved_d;
   logic                  limit_q, limit_d;

   logic                  tmr_load, tmr_en, tmr_zero;
   logic [HOLD_WIDTH-1:0] tmr_val;

   logic load_req, up_req, dn_req, one_req, at_end;

   assign load_req = ~CC_POSTRACKER_load_InLow;
   assign up_req   = ~CC_POSTRACKER_up_InLow;
   assign dn_req   = ~CC_POSTRACKER_down_InLow;
   assign one_req  = up_req ^ dn_req;
   assign at_end   = (up_req && (pos_q == POS_MAX)) || (dn_req && (pos_q == '0));

   cc_hold_timer #(.WIDTH(HOLD_WIDTH)) u_timer (
      .clk_i      (CC_POSTRACKER_CLOCK_50),
      .rst_i      (CC_POSTRACKER_RESET_InHigh),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .zero_o     (tmr_zero)
   );

   always_ff @(posedge CC_POSTRACKER_CLOCK_50 or posedge CC_POSTRACKER_RESET_InHigh) begin
      if (CC_POSTRACKER_RESET_InHigh) state_q <= IDLE;
      else                            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (load_req) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (one_req) state_d = at_end ? LOCK : HOLD;
            HOLD:    if (tmr_zero) state_d = IDLE;
            LOCK:    if (!up_req && !dn_req) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Pulses are computed only from IDLE, so LOCK and HOLD stay silent.
   always_comb begin
      pos_d    = pos_q;
      moved_d  = 1'b0;
      limit_d  = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = HOLD_RELOAD;
      tmr_en   = (state_q == HOLD);
      if (load_req) begin
         pos_d    = CC_POSTRACKER_loadData_InBUS;
         tmr_load = 1'b1;
         tmr_val  = '0;
      end else if ((state_q == IDLE) && one_req) begin
         if (at_end) begin
            limit_d = 1'b1;
         end else begin
            pos_d    = up_req ? pos_q + DATAWIDTH'(1) : pos_q - DATAWIDTH'(1);
            moved_d  = 1'b1;
            tmr_load = 1'b1;
         end
      end
   end

   always_ff @(posedge CC_POSTRACKER_CLOCK_50 or posedge CC_POSTRACKER_RESET_InHigh) begin
      if (CC_POSTRACKER_RESET_InHigh) begin
         pos_q   <= INIT_POS;
         moved_q <= 1'b0;
         limit_q <= 1'b0;
      end else begin
         pos_q   <= pos_d;
         moved_q <= moved_d;
         limit_q <= limit_d;
      end
   end

   assign CC_POSTRACKER_data_OutBUS   = pos_q;
   assign CC_POSTRACKER_moved_OutHigh = moved_q;
   assign CC_POSTRACKER_limit_OutHigh = limit_q;

endmodule

// File: tb/tb_cc_pos_tracker.sv
// Scenario bench for cc_pos_tracker with a short hold-off (HOLD_CYCLES=3);
// expected outputs are queued as stimulus is applied and checked after each edge.
module tb_cc_pos_tracker;

   typedef struct {
      logic       ld;
      logic [2:0] ldv;
      logic       up;
      logic       dn;
      logic [2:0] d;
      logic       mv;
      logic       lm;
   } vec_t;

   typedef struct {
      logic [2:0] d;
      logic       mv;
      logic       lm;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       load_n = 1'b1;
   logic [2:0] load_data = 3'd0;
   logic       up_n = 1'b1;
   logic       dn_n = 1'b1;
   logic [2:0] data;
   logic       moved, limit;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];

   cc_pos_tracker #(
      .DATAWIDTH   (3),
      .INIT_POS    (3'd4),
      .HOLD_CYCLES (3),
      .HOLD_WIDTH  (4)
   ) dut (
      .CC_POSTRACKER_CLOCK_50       (clk),
      .CC_POSTRACKER_RESET_InHigh   (rst),
      .CC_POSTRACKER_load_InLow     (load_n),
      .CC_POSTRACKER_loadData_InBUS (load_data),
      .CC_POSTRACKER_up_InLow       (up_n),
      .CC_POSTRACKER_down_InLow     (dn_n),
      .CC_POSTRACKER_data_OutBUS    (data),
      .CC_POSTRACKER_moved_OutHigh  (moved),
      .CC_POSTRACKER_limit_OutHigh  (limit)
   );

   always #5 clk = ~clk;

   // Inputs are active-low: 0 means asserted.
   function automatic vec_t mk(logic ld, logic [2:0] ldv, logic up, logic dn,
                               logic [2:0] d, logic mv, logic lm);
      vec_t v;
      v.ld = ld; v.ldv = ldv; v.up = up; v.dn = dn;
      v.d = d; v.mv = mv; v.lm = lm;
      return v;
   endfunction

   task automatic test_reset();
      vec_t v[$];
      exp_t e;
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back('{3'd4, 1'b0, 1'b0});
      e = exp_q.pop_front(); checks++;
      if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
         errors++;
         $display("FAIL reset_init: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                  data, moved, limit, e.d, e.mv, e.lm);
      end
      rst = 1'b0;
      v.push_back(mk(0, 3'd5, 1, 1, 3'd5, 0, 0));
      v.push_back(mk(1, 3'd0, 0, 1, 3'd6, 1, 0));
      v.push_back(mk(1, 3'd0, 1, 1, 3'd6, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL reset_pre[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
      // Mid-HOLD at position 6: reset between edges must act at once.
      #3 rst = 1'b1;
      #1;
      exp_q.push_back('{3'd4, 1'b0, 1'b0});
      e = exp_q.pop_front(); checks++;
      if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
         errors++;
         $display("FAIL reset_async: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                  data, moved, limit, e.d, e.mv, e.lm);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      v.delete();
      v.push_back(mk(1, 3'd0, 0, 1, 3'd5, 1, 0));
      for (int c = 0; c < 4; c++) v.push_back(mk(1, 3'd0, 1, 1, 3'd5, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL reset_post[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
   endtask

   task automatic test_held_up();
      vec_t v[$];
      exp_t e;
      v.push_back(mk(0, 3'd4, 1, 1, 3'd4, 0, 0));
      for (int c = 0; c < 16; c++) begin
         int unsigned steps;
         steps = (c / 4 < 2) ? c / 4 : 2;
         v.push_back(mk(1, 3'd0, 0, 1, 3'(5 + steps),
                        ((c % 4) == 0) && (c < 12), c == 12));
      end
      v.push_back(mk(1, 3'd0, 1, 1, 3'd7, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL held_up[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
   endtask

   task automatic test_down_floor();
      vec_t v[$];
      exp_t e;
      v.push_back(mk(0, 3'd1, 1, 1, 3'd1, 0, 0));
      for (int c = 0; c < 8; c++) v.push_back(mk(1, 3'd0, 1, 0, 3'd0, c == 0, c == 4));
      v.push_back(mk(1, 3'd0, 1, 1, 3'd0, 0, 0));
      v.push_back(mk(1, 3'd0, 1, 0, 3'd0, 0, 1));
      v.push_back(mk(1, 3'd0, 1, 1, 3'd0, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL down_floor[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
   endtask

   task automatic test_simultaneous();
      vec_t v[$];
      exp_t e;
      v.push_back(mk(0, 3'd3, 1, 1, 3'd3, 0, 0));
      for (int c = 0; c < 5; c++) v.push_back(mk(1, 3'd0, 0, 0, 3'd3, 0, 0));
      v.push_back(mk(1, 3'd0, 1, 1, 3'd3, 0, 0));
      v.push_back(mk(1, 3'd0, 0, 1, 3'd4, 1, 0));
      for (int c = 0; c < 3; c++) v.push_back(mk(1, 3'd0, 1, 1, 3'd4, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL simultaneous[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
   endtask

   task automatic test_load_in_hold();
      vec_t v[$];
      exp_t e;
      v.push_back(mk(1, 3'd0, 0, 1, 3'd5, 1, 0));
      v.push_back(mk(0, 3'd2, 0, 1, 3'd2, 0, 0));
      v.push_back(mk(1, 3'd0, 0, 1, 3'd3, 1, 0));
      for (int c = 0; c < 4; c++) v.push_back(mk(1, 3'd0, 1, 1, 3'd3, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL load_in_hold[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
   endtask

   task automatic test_short_tap();
      vec_t v[$];
      exp_t e;
      v.push_back(mk(0, 3'd0, 1, 1, 3'd0, 0, 0));
      v.push_back(mk(1, 3'd0, 0, 1, 3'd1, 1, 0));
      for (int c = 0; c < 8; c++) v.push_back(mk(1, 3'd0, 1, 1, 3'd1, 0, 0));
      foreach (v[i]) begin
         load_n = v[i].ld; load_data = v[i].ldv; up_n = v[i].up; dn_n = v[i].dn;
         exp_q.push_back('{v[i].d, v[i].mv, v[i].lm});
         @(posedge clk); #1;
         e = exp_q.pop_front(); checks++;
         if ({data, moved, limit} !== {e.d, e.mv, e.lm}) begin
            errors++;
            $display("FAIL short_tap[%0d]: got data=%0d moved=%b limit=%b, exp data=%0d moved=%b limit=%b",
                     i, data, moved, limit, e.d, e.mv, e.lm);
         end
      end
   endtask

   initial begin
      test_reset();
      test_held_up();
      test_down_floor();
      test_simultaneous();
      test_load_in_hold();
      test_short_tap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cc_pos_tracker.md
# cc_pos_tracker

Registered position tracker that sits directly upstream of the position zero-comparator. It holds a DATAWIDTH-bit object position and moves it one step up or down on request. It rate-limits held requests with a hold-off timer and saturates at both ends. Its position bus feeds the comparator's data input unchanged.

## Interface

**Parameters**
- DATAWIDTH, 3: width of the position bus.
- INIT_POS, 3'd4: position loaded at reset.
- HOLD_CYCLES, 12500000: hold-off cycles after each move. Must be ≥1.
- HOLD_WIDTH, 24: timer width. Must satisfy 2^HOLD_WIDTH > HOLD_CYCLES.

**Ports**
- CC_POSTRACKER_CLOCK_50, in, 1: single clock; all state updates on its rising edge.
- CC_POSTRACKER_RESET_InHigh, in, 1: reset, asynchronous, active-high.
- CC_POSTRACKER_load_InLow, in, 1: active-low synchronous load request.
- CC_POSTRACKER_loadData_InBUS, in, DATAWIDTH: value written on load.
- CC_POSTRACKER_up_InLow, in, 1: active-low step-up request, level-sensitive, already synchronized.
- CC_POSTRACKER_down_InLow, in, 1: active-low step-down request, level-sensitive, already synchronized.
- CC_POSTRACKER_data_OutBUS, out, DATAWIDTH: current position. Registered; drives the comparator input.
- CC_POSTRACKER_moved_OutHigh, out, 1: one-cycle pulse on the cycle the position changes.
- CC_POSTRACKER_limit_OutHigh, out, 1: one-cycle pulse when a request is refused at an end stop.

## Operation

**Reset values**
- data_OutBUS = INIT_POS.
- moved_OutHigh = 0 and limit_OutHigh = 0.
- State = IDLE and timer = 0.

**States**
- IDLE
  - Exactly one request active and the move is in range: step by ±1, pulse moved, load timer with HOLD_CYCLES-1, go to HOLD.
  - Up requested at MAX (2^DATAWIDTH-1), or down requested at 0: position unchanged, pulse limit, go to LOCK.
  - Both requests active, or neither: no action, stay in IDLE.
- HOLD
  - Timer decrements each cycle; requests are ignored.
  - On the edge where timer == 0, go to IDLE.
- LOCK
  - Stay until up_InLow and down_InLow are both high (released) on a sampled edge, then go to IDLE.
  - No outputs pulse while in LOCK.

**Load**
- load_InLow low has priority over everything in every state.
- Position takes loadData_InBUS, timer clears, state goes to IDLE.
- moved and limit do not pulse on load.

**Arithmetic**
- Unsigned arithmetic, no wrap-around.
- Position never leaves [0, 2^DATAWIDTH-1].

**Outputs**
- moved and limit are mutually exclusive.
- Both are registered, asserted for exactly one cycle, and coincident with the state transition.

## Timing

- **Step latency:** request sampled in IDLE at edge k; new position and moved pulse visible after edge k.
- **Auto-repeat:** a held in-range request steps once every HOLD_CYCLES+1 cycles (HOLD_CYCLES in HOLD plus 1 in IDLE).
- **Request release:** a request released during HOLD causes no further step.
- **Reaching the end:** a step that reaches 0 or MAX completes normally. A request still held after HOLD produces one limit pulse, then LOCK.
- **Reset mid-HOLD or mid-LOCK:** asynchronous return to the reset values, effective immediately and independent of the clock.
- **Load on the same edge as a request:** load wins; the request is re-evaluated from IDLE on the next edge.
- **Downstream:** data_OutBUS == 0 persists until moved away, so the comparator output is glitch-free and register-driven.

## Structure

- **Shared package cc_pos_pkg:**
  - State encoding constants: IDLE=2'b00, HOLD=2'b01, LOCK=2'b10.
  - POS_MAX derived from DATAWIDTH.
  - Default HOLD_CYCLES.
- **Sub-module cc_hold_timer:** loadable down-counter.
  - Ports: load, load value, enable, zero flag.
  - Instantiated once; the tracker FSM drives load/enable and consumes the zero flag.
- **Position register and FSM:** in the top module, as separate sequential and next-state blocks.

## Test plan

- **Reset:** assert reset mid-HOLD with position 6 → data=4, moved=0, limit=0 immediately; IDLE on release.
- **Held up from 4, HOLD_CYCLES=3:**
  - Positions 5, 6, 7 at 4-cycle spacing, with moved pulsed each step.
  - The next evaluation in IDLE pulses limit once, then LOCK.
  - No further pulses until release.
- **Down from 1:**
  - One step to 0, and the comparator output goes low.
  - Continued holding gives one limit pulse, then LOCK.
  - Releasing then pressing down again gives another limit pulse and no change.
- **Simultaneous requests:** up and down both low in IDLE at position 3 → position stays 3, no pulses, state stays IDLE.
- **Load during HOLD:** load=0 with loadData=2 → data=2 after the next edge, no moved pulse, IDLE; a held up request then steps to 3 one cycle later.
- **Short tap:** up low for a single cycle at position 0 → position 1 and one moved pulse; no repeat after HOLD expires.
